ecpri_resp_sched: RTL and testbench

Response scheduler and sequencer for the eCPRI transmit builder. It accepts eCPRI remote-memory write-response and read-response requests from the receive side. When both are pending it arbitrates round-robin, then drives one granted request at a time into the transmit builder (send_write_resp / send_read_resp level, resp_payload_len). It waits for the built packet, hands the packet to the MAC, then clears the builder for the next response.

---
 rtl/ecpri_pkg.sv | 20 ++
 rtl/ecpri_rr_arb2.sv | 32 +++
 rtl/ecpri_resp_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_ecpri_resp_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecpri_pkg.sv
// ecpri_pkg: constants shared by the eCPRI response scheduler and the
// transmit builder.
//   - DEFAULT_LEN_WIDTH : payload length width, also used by the builder
//   - sched_state_e     : scheduler states IDLE=0, BUILD=1, HANDOFF=2, CLEAR=3
//   - GRANT_WR/GRANT_RD : ids stored in the round-robin history bit
package ecpri_pkg;

    localparam int DEFAULT_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUILD   = 2'd1,
        HANDOFF = 2'd2,
        CLEAR   = 2'd3
    } sched_state_e;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/ecpri_rr_arb2.sv
// ecpri_rr_arb2: purely combinational two-requester round-robin arbiter.
// The caller owns the history bit (i_last_grant).
// Ports:
//   i_req[1:0]   : bit 0 = write-response request, bit 1 = read-response request
//   i_last_grant : GRANT_WR / GRANT_RD, side that won the previous grant
//   i_enable     : arbitration allowed this cycle
//   o_grant[1:0] : one-hot grant (bit 0 write, bit 1 read), 0 when none
module ecpri_rr_arb2
    import ecpri_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    input  logic       i_enable,
    output logic [1:0] o_grant
);

    // Grant selection: a tie goes to the side that did not win last time.
    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = (i_last_grant == GRANT_RD) ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end else begin
            o_grant = 2'b00;
        end
    end

endmodule

// File: rtl/ecpri_resp_sched.sv
// ecpri_resp_sched: schedules eCPRI remote-memory write/read responses into
// the transmit builder, hands each built packet to the MAC, then clears the
// builder before the next response.
// Optional feature macro: ECPRI_SCHED_TIMEOUT_EN (abort a BUILD that lasts
// TIMEOUT_CYCLES cycles without cpri_pkt_rdy_flg); undefined by default.
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   wr_req/wr_len/wr_ack         : write-response request, length, grant pulse
//   rd_req/rd_len/rd_ack         : read-response request, length, grant pulse
//   send_write_resp/send_read_resp/resp_payload_len : builder selection + length
//   cpri_pkt_rdy_flg             : builder has the packet complete in RAM
//   tx_clr                       : builder clear, held CLR_CYCLES cycles
//   mac_tx_req/mac_tx_done       : MAC handoff handshake
//   busy                         : state != IDLE
//   pkt_cnt                      : completed responses (wrapping)
//   timeout_err                  : one-cycle BUILD abort pulse (0 without macro)
module ecpri_resp_sched
    import ecpri_pkg::*;
#(
    parameter int LEN_WIDTH      = DEFAULT_LEN_WIDTH,
    parameter int CLR_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_req,
    input  logic [LEN_WIDTH-1:0] wr_len,
    output logic                 wr_ack,
    input  logic                 rd_req,
    input  logic [LEN_WIDTH-1:0] rd_len,
    output logic                 rd_ack,
    output logic                 send_write_resp,
    output logic                 send_read_resp,
    output logic [LEN_WIDTH-1:0] resp_payload_len,
    input  logic                 cpri_pkt_rdy_flg,
    output logic                 tx_clr,
    output logic                 mac_tx_req,
    input  logic                 mac_tx_done,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic                 timeout_err
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    sched_state_e         r_state, w_state_nxt;
    logic                 r_last_grant, w_last_grant_nxt;
    logic                 r_wr_ack, w_wr_ack_nxt;
    logic                 r_rd_ack, w_rd_ack_nxt;
    logic                 r_send_wr, w_send_wr_nxt;
    logic                 r_send_rd, w_send_rd_nxt;
    logic [LEN_WIDTH-1:0] r_len, w_len_nxt;
    logic                 r_tx_clr, w_tx_clr_nxt;
    logic                 r_mac_req, w_mac_req_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [CNT_WIDTH-1:0] r_pkt_cnt, w_pkt_cnt_nxt;
    logic                 r_to_err, w_to_err_nxt;
    logic [CLR_W-1:0]     r_clr_cnt, w_clr_cnt_nxt;
    logic [1:0]           w_grant;

`ifdef ECPRI_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]      r_to_cnt, w_to_cnt_nxt;
`else
    logic                 w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    ecpri_rr_arb2 u_arb (
        .i_req        ({rd_req, wr_req}),
        .i_last_grant (r_last_grant),
        .i_enable     (r_state == IDLE),
        .o_grant      (w_grant)
    );

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_wr_ack_nxt     = 1'b0;
        w_rd_ack_nxt     = 1'b0;
        w_send_wr_nxt    = r_send_wr;
        w_send_rd_nxt    = r_send_rd;
        w_len_nxt        = r_len;
        w_tx_clr_nxt     = r_tx_clr;
        w_mac_req_nxt    = r_mac_req;
        w_pkt_cnt_nxt    = r_pkt_cnt;
        w_to_err_nxt     = 1'b0;
        w_clr_cnt_nxt    = r_clr_cnt;
`ifdef ECPRI_SCHED_TIMEOUT_EN
        w_to_cnt_nxt     = r_to_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_grant[0]) begin
                    w_state_nxt      = BUILD;
                    w_wr_ack_nxt     = 1'b1;
                    w_send_wr_nxt    = 1'b1;
                    w_send_rd_nxt    = 1'b0;
                    w_len_nxt        = wr_len;
                    w_last_grant_nxt = GRANT_WR;
`ifdef ECPRI_SCHED_TIMEOUT_EN
                    w_to_cnt_nxt     = {TO_W{1'b0}};
`endif
                end else if (w_grant[1]) begin
                    w_state_nxt      = BUILD;
                    w_rd_ack_nxt     = 1'b1;
                    w_send_wr_nxt    = 1'b0;
                    w_send_rd_nxt    = 1'b1;
                    w_len_nxt        = rd_len;
                    w_last_grant_nxt = GRANT_RD;
`ifdef ECPRI_SCHED_TIMEOUT_EN
                    w_to_cnt_nxt     = {TO_W{1'b0}};
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUILD: begin
                if (cpri_pkt_rdy_flg) begin
                    w_state_nxt   = HANDOFF;
                    w_mac_req_nxt = 1'b1;
                end else begin
`ifdef ECPRI_SCHED_TIMEOUT_EN
                    // r_to_cnt counts completed BUILD cycles; abort after the last allowed one.
                    if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        w_state_nxt   = CLEAR;
                        w_to_err_nxt  = 1'b1;
                        w_send_wr_nxt = 1'b0;
                        w_send_rd_nxt = 1'b0;
                        w_tx_clr_nxt  = 1'b1;
                        w_clr_cnt_nxt = CLR_W'(CLR_CYCLES - 1);
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                    end
`else
                    w_state_nxt = BUILD;
`endif
                end
            end
            HANDOFF: begin
                if (mac_tx_done) begin
                    w_state_nxt   = CLEAR;
                    w_mac_req_nxt = 1'b0;
                    w_pkt_cnt_nxt = r_pkt_cnt + CNT_WIDTH'(1);
                    w_send_wr_nxt = 1'b0;
                    w_send_rd_nxt = 1'b0;
                    w_tx_clr_nxt  = 1'b1;
                    w_clr_cnt_nxt = CLR_W'(CLR_CYCLES - 1);
                end else begin
                    w_state_nxt = HANDOFF;
                end
            end
            CLEAR: begin
                // Down-counter loaded with CLR_CYCLES-1 so tx_clr spans exactly CLR_CYCLES cycles.
                if (r_clr_cnt == {CLR_W{1'b0}}) begin
                    w_state_nxt  = IDLE;
                    w_tx_clr_nxt = 1'b0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt - CLR_W'(1);
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_send_wr_nxt = 1'b0;
                w_send_rd_nxt = 1'b0;
                w_tx_clr_nxt  = 1'b0;
                w_mac_req_nxt = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_RD;
            r_wr_ack     <= 1'b0;
            r_rd_ack     <= 1'b0;
            r_send_wr    <= 1'b0;
            r_send_rd    <= 1'b0;
            r_len        <= {LEN_WIDTH{1'b0}};
            r_tx_clr     <= 1'b0;
            r_mac_req    <= 1'b0;
            r_busy       <= 1'b0;
            r_pkt_cnt    <= {CNT_WIDTH{1'b0}};
            r_to_err     <= 1'b0;
            r_clr_cnt    <= {CLR_W{1'b0}};
`ifdef ECPRI_SCHED_TIMEOUT_EN
            r_to_cnt     <= {TO_W{1'b0}};
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_wr_ack     <= w_wr_ack_nxt;
            r_rd_ack     <= w_rd_ack_nxt;
            r_send_wr    <= w_send_wr_nxt;
            r_send_rd    <= w_send_rd_nxt;
            r_len        <= w_len_nxt;
            r_tx_clr     <= w_tx_clr_nxt;
            r_mac_req    <= w_mac_req_nxt;
            r_busy       <= w_busy_nxt;
            r_pkt_cnt    <= w_pkt_cnt_nxt;
            r_to_err     <= w_to_err_nxt;
            r_clr_cnt    <= w_clr_cnt_nxt;
`ifdef ECPRI_SCHED_TIMEOUT_EN
            r_to_cnt     <= w_to_cnt_nxt;
`endif
        end
    end

    assign wr_ack           = r_wr_ack;
    assign rd_ack           = r_rd_ack;
    assign send_write_resp  = r_send_wr;
    assign send_read_resp   = r_send_rd;
    assign resp_payload_len = r_len;
    assign tx_clr           = r_tx_clr;
    assign mac_tx_req       = r_mac_req;
    assign busy             = r_busy;
    assign pkt_cnt          = r_pkt_cnt;
    assign timeout_err      = r_to_err;

endmodule

// File: tb/tb_ecpri_resp_sched.sv
// Self-checking bench for ecpri_resp_sched. A transaction-level model tracks
// the round-robin history and the completed-packet count; each scenario task
// drives stimulus and compares DUT outputs against that model.
module tb_ecpri_resp_sched;

    localparam int LW  = 8;
    localparam int CLR = 2;
    localparam int TO  = 16;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          wr_req = 1'b0;
    logic [LW-1:0] wr_len = '0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic [LW-1:0] rd_len = '0;
    logic          rd_ack;
    logic          send_write_resp, send_read_resp;
    logic [LW-1:0] resp_payload_len;
    logic          cpri_pkt_rdy_flg = 1'b0;
    logic          tx_clr, mac_tx_req;
    logic          mac_tx_done = 1'b0;
    logic          busy;
    logic [CW-1:0] pkt_cnt;
    logic          timeout_err;

    int            n_cmp  = 0;
    int            n_fail = 0;
    int            m_last = 1;        // model round-robin history: 0 write, 1 read
    logic [CW-1:0] m_cnt  = '0;       // model completed-packet count

    ecpri_resp_sched #(
        .LEN_WIDTH(LW), .CLR_CYCLES(CLR), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req(wr_req), .wr_len(wr_len), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_len(rd_len), .rd_ack(rd_ack),
        .send_write_resp(send_write_resp), .send_read_resp(send_read_resp),
        .resp_payload_len(resp_payload_len),
        .cpri_pkt_rdy_flg(cpri_pkt_rdy_flg), .tx_clr(tx_clr),
        .mac_tx_req(mac_tx_req), .mac_tx_done(mac_tx_done),
        .busy(busy), .pkt_cnt(pkt_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Round-robin rule: on a tie the side that did not win last time wins.
    function automatic int pick(input bit w, input bit r, input int last);
        if (w && r) return (last == 1) ? 0 : 1;
        else if (w) return 0;
        else return 1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called at the first BUILD cycle (ack cycle); walks one response to IDLE.
    task automatic serve_one(input int side, input logic [LW-1:0] len, input bit drop,
                             input int rdy_dly, input int done_dly);
        logic ew, er;
        ew = (side == 0);
        er = (side == 1);
        n_cmp++;
        if (wr_ack !== ew || rd_ack !== er || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_ack: wr_ack=%0b rd_ack=%0b busy=%0b required wr_ack=%0b rd_ack=%0b busy=1",
                     wr_ack, rd_ack, busy, ew, er);
        end
        n_cmp++;
        if (send_write_resp !== ew || send_read_resp !== er || resp_payload_len !== len) begin
            n_fail++;
            $display("FAIL select: send_wr=%0b send_rd=%0b len=%0d required %0b %0b %0d",
                     send_write_resp, send_read_resp, resp_payload_len, ew, er, len);
        end
        if (drop) begin
            if (side == 0) wr_req = 1'b0;
            else rd_req = 1'b0;
        end
        for (int i = 0; i < rdy_dly; i++) begin
            tick;
            n_cmp++;
            if (wr_ack !== 1'b0 || rd_ack !== 1'b0 || mac_tx_req !== 1'b0 || busy !== 1'b1 ||
                send_write_resp !== ew || send_read_resp !== er || tx_clr !== 1'b0) begin
                n_fail++;
                $display("FAIL build_wait: ack=%0b%0b mac_req=%0b busy=%0b send=%0b%0b tx_clr=%0b required ack=00 mac_req=0 busy=1 send=%0b%0b tx_clr=0",
                         wr_ack, rd_ack, mac_tx_req, busy, send_write_resp, send_read_resp, tx_clr, ew, er);
            end
        end
        cpri_pkt_rdy_flg = 1'b1;
        tick;
        cpri_pkt_rdy_flg = 1'b0;
        n_cmp++;
        if (mac_tx_req !== 1'b1 || wr_ack !== 1'b0 || rd_ack !== 1'b0 ||
            send_write_resp !== ew || send_read_resp !== er) begin
            n_fail++;
            $display("FAIL handoff_entry: mac_req=%0b ack=%0b%0b send=%0b%0b required mac_req=1 ack=00 send=%0b%0b",
                     mac_tx_req, wr_ack, rd_ack, send_write_resp, send_read_resp, ew, er);
        end
        for (int i = 0; i < done_dly; i++) begin
            tick;
            n_cmp++;
            if (mac_tx_req !== 1'b1 || send_write_resp !== ew || send_read_resp !== er || pkt_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL handoff_hold: mac_req=%0b send=%0b%0b pkt_cnt=%0d required 1 %0b%0b %0d",
                         mac_tx_req, send_write_resp, send_read_resp, pkt_cnt, ew, er, m_cnt);
            end
        end
        mac_tx_done = 1'b1;
        tick;
        mac_tx_done = 1'b0;
        m_cnt  = m_cnt + 16'd1;
        m_last = side;
        for (int k = 0; k < CLR; k++) begin
            if (k > 0) tick;
            n_cmp++;
            if (tx_clr !== 1'b1 || mac_tx_req !== 1'b0 || send_write_resp !== 1'b0 ||
                send_read_resp !== 1'b0 || pkt_cnt !== m_cnt || wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_%0d: tx_clr=%0b mac_req=%0b send=%0b%0b pkt_cnt=%0d ack=%0b%0b required 1 0 00 %0d 00",
                         k, tx_clr, mac_tx_req, send_write_resp, send_read_resp, pkt_cnt, wr_ack, rd_ack, m_cnt);
            end
        end
        tick;
        n_cmp++;
        if (tx_clr !== 1'b0 || busy !== 1'b0 || wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle: tx_clr=%0b busy=%0b ack=%0b%0b required 0 0 00",
                     tx_clr, busy, wr_ack, rd_ack);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) tick;
        n_cmp++;
        if ({wr_ack, rd_ack, send_write_resp, send_read_resp, tx_clr, mac_tx_req, busy, timeout_err} !== 8'h00 ||
            resp_payload_len !== 8'd0 || pkt_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: flags=%b len=%0d pkt_cnt=%0d required all zero",
                     {wr_ack, rd_ack, send_write_resp, send_read_resp, tx_clr, mac_tx_req, busy, timeout_err},
                     resp_payload_len, pkt_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_cnt  = '0;
        m_last = 1;
        tick;
    endtask

    task automatic test_single_write;
        wr_req = 1'b1;
        wr_len = 8'd20;
        tick;
        serve_one(pick(1'b1, 1'b0, m_last), 8'd20, 1'b1, 2, 1);
    endtask

    task automatic test_simultaneous;
        logic [LW-1:0] wl;
        test_reset;
        wl = 8'($urandom_range(1, 255));
        wr_req = 1'b1; wr_len = wl;
        rd_req = 1'b1; rd_len = 8'd4;
        tick;
        serve_one(pick(1'b1, 1'b1, m_last), wl, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3));
        tick;
        serve_one(pick(1'b0, 1'b1, m_last), 8'd4, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    task automatic test_fairness;
        int side;
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            wr_len = 8'($urandom_range(0, 255));
            rd_len = 8'($urandom_range(0, 255));
            side = pick(1'b1, 1'b1, m_last);
            tick;
            serve_one(side, (side == 0) ? wr_len : rd_len, 1'b0,
                      $urandom_range(0, 4), $urandom_range(0, 4));
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick;
    endtask

    task automatic test_stray;
        cpri_pkt_rdy_flg = 1'b1;
        tick;
        cpri_pkt_rdy_flg = 1'b0;
        mac_tx_done = 1'b1;
        tick;
        mac_tx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++;
            if (busy !== 1'b0 || wr_ack !== 1'b0 || rd_ack !== 1'b0 || mac_tx_req !== 1'b0 ||
                tx_clr !== 1'b0 || pkt_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL stray_events: busy=%0b ack=%0b%0b mac_req=%0b tx_clr=%0b pkt_cnt=%0d required 0 00 0 0 %0d",
                         busy, wr_ack, rd_ack, mac_tx_req, tx_clr, pkt_cnt, m_cnt);
            end
        end
    endtask

    task automatic test_random;
        int side;
        for (int it = 0; it < 20; it++) begin
            if (!wr_req && $urandom_range(0, 1) == 1) begin wr_req = 1'b1; wr_len = 8'($urandom_range(0, 255)); end
            if (!rd_req && $urandom_range(0, 1) == 1) begin rd_req = 1'b1; rd_len = 8'($urandom_range(0, 255)); end
            if (!wr_req && !rd_req) begin
                if ($urandom_range(0, 1) == 1) begin wr_req = 1'b1; wr_len = 8'($urandom_range(0, 255)); end
                else begin rd_req = 1'b1; rd_len = 8'($urandom_range(0, 255)); end
            end
            side = pick(wr_req, rd_req, m_last);
            tick;
            serve_one(side, (side == 0) ? wr_len : rd_len, 1'b1,
                      $urandom_range(0, 5), $urandom_range(0, 5));
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick;
    endtask

    task automatic test_async_reset;
        wr_req = 1'b1;
        wr_len = 8'($urandom_range(1, 255));
        tick;
        wr_req = 1'b0;
        cpri_pkt_rdy_flg = 1'b1;
        tick;
        cpri_pkt_rdy_flg = 1'b0;
        n_cmp++;
        if (mac_tx_req !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre_handoff: mac_req=%0b required 1", mac_tx_req);
        end
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        m_cnt  = '0;
        m_last = 1;
        n_cmp++;
        if ({wr_ack, rd_ack, send_write_resp, send_read_resp, tx_clr, mac_tx_req, busy, timeout_err} !== 8'h00 ||
            resp_payload_len !== 8'd0 || pkt_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL async_reset: flags=%b len=%0d pkt_cnt=%0d required all zero",
                     {wr_ack, rd_ack, send_write_resp, send_read_resp, tx_clr, mac_tx_req, busy, timeout_err},
                     resp_payload_len, pkt_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_cmp++;
            if (busy !== 1'b0 || wr_ack !== 1'b0 || rd_ack !== 1'b0 || pkt_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL post_reset_idle: busy=%0b ack=%0b%0b pkt_cnt=%0d required 0 00 %0d",
                         busy, wr_ack, rd_ack, pkt_cnt, m_cnt);
            end
        end
    endtask

    task automatic test_timeout;
        logic [LW-1:0] rl;
        rl = 8'($urandom_range(0, 255));
        rd_req = 1'b1;
        rd_len = rl;
        tick;
        rd_req = 1'b0;
        m_last = 1;
        n_cmp++;
        if (rd_ack !== 1'b1 || send_read_resp !== 1'b1 || resp_payload_len !== rl) begin
            n_fail++;
            $display("FAIL timeout_grant: rd_ack=%0b send_rd=%0b len=%0d required 1 1 %0d",
                     rd_ack, send_read_resp, resp_payload_len, rl);
        end
`ifdef ECPRI_SCHED_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            tick;
            n_cmp++;
            if (timeout_err !== 1'b0 || busy !== 1'b1 || send_read_resp !== 1'b1 || tx_clr !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early_%0d: err=%0b busy=%0b send_rd=%0b tx_clr=%0b required 0 1 1 0",
                         i, timeout_err, busy, send_read_resp, tx_clr);
            end
        end
        tick;
        n_cmp++;
        if (timeout_err !== 1'b1 || tx_clr !== 1'b1 || send_read_resp !== 1'b0 || mac_tx_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: err=%0b tx_clr=%0b send_rd=%0b mac_req=%0b required 1 1 0 0",
                     timeout_err, tx_clr, send_read_resp, mac_tx_req);
        end
        tick;
        n_cmp++;
        if (timeout_err !== 1'b0 || tx_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_clear: err=%0b tx_clr=%0b required 0 1", timeout_err, tx_clr);
        end
        tick;
`else
        for (int i = 0; i < 40; i++) begin
            tick;
            n_cmp++;
            if (timeout_err !== 1'b0 || busy !== 1'b1 || send_read_resp !== 1'b1 || tx_clr !== 1'b0) begin
                n_fail++;
                $display("FAIL build_no_timeout_%0d: err=%0b busy=%0b send_rd=%0b tx_clr=%0b required 0 1 1 0",
                         i, timeout_err, busy, send_read_resp, tx_clr);
            end
        end
        cpri_pkt_rdy_flg = 1'b1;
        tick;
        cpri_pkt_rdy_flg = 1'b0;
        mac_tx_done = 1'b1;
        tick;
        mac_tx_done = 1'b0;
        m_cnt = m_cnt + 16'd1;
        repeat (CLR) tick;
`endif
        n_cmp++;
        if (busy !== 1'b0 || tx_clr !== 1'b0 || pkt_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL timeout_end: busy=%0b tx_clr=%0b pkt_cnt=%0d required 0 0 %0d",
                     busy, tx_clr, pkt_cnt, m_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_simultaneous;
        test_fairness;
        test_stray;
        test_random;
        test_async_reset;
        test_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
